// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART command frame parser
package uart_pkg;

  // Parser state encoding, kept as plain constants for legacy tools
  typedef logic [2:0] parser_state_t;

  localparam parser_state_t ST_IDLE    = 3'd0;
  localparam parser_state_t ST_GOT_H0  = 3'd1;
  localparam parser_state_t ST_GET_LEN = 3'd2;
  localparam parser_state_t ST_DATA    = 3'd3;
  localparam parser_state_t ST_GET_CHK = 3'd4;

  // Error codes reported on err_code_o
  localparam logic [1:0] ERR_LEN = 2'd0;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  // Default header bytes
  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - clearable up-counter with terminal-count expire strobe
module uart_gap_timer #(
  parameter logic [31:0] TERM = 32'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Count while enabled, clear has priority, park at the terminal value
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 32'd0;
    end else if (en_i && (count_q != TERM - 32'd1)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && (count_q == TERM - 32'd1);

endmodule

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - delineates HDR0 HDR1 LEN payload CHK frames from a UART byte stream
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ  = 32'd50_000_000,
  parameter logic [31:0] BAUDRATE  = 32'd115_200,
  parameter int          MAX_LEN   = 64,
  parameter logic [7:0]  HDR0      = HDR0_DEF,
  parameter logic [7:0]  HDR1      = HDR1_DEF,
  parameter int          GAP_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       pl_valid_o,
  output logic [7:0] pl_data_o,
  output logic       pl_first_o,
  output logic       pl_last_o,
  output logic [7:0] frame_len_o,
  output logic       frame_done_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o
);

  // One byte time is 10 bit times
  localparam logic [31:0] TIMEOUT_CYC = (CLK_FREQ / BAUDRATE) * 32'd10 * 32'(GAP_BYTES);
  localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);

  parser_state_t state_q, state_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic          pl_valid_q, pl_valid_d;
  logic [7:0]    pl_data_q, pl_data_d;
  logic          pl_first_q, pl_first_d;
  logic          pl_last_q, pl_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          tmo_expire;
  logic          tmo_fire;

  // A byte on the expiry cycle wins over the timeout
  assign tmo_fire = tmo_expire && !rx_valid_i;

  uart_gap_timer #(
    .TERM(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q != ST_IDLE),
    .clr_i    (rx_valid_i || (state_q == ST_IDLE) || tmo_fire),
    .expire_o (tmo_expire)
  );

  // Frame FSM: header hunt, length check, cut-through payload, checksum compare
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    frame_len_d = frame_len_q;
    pl_valid_d  = 1'b0;
    pl_data_d   = pl_data_q;
    pl_first_d  = 1'b0;
    pl_last_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    if (tmo_fire) begin
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = ST_IDLE;
    end else if (rx_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data_i == HDR0) state_d = ST_GOT_H0;
        end
        ST_GOT_H0: begin
          if (rx_data_i == HDR1)      state_d = ST_GET_LEN;
          else if (rx_data_i == HDR0) state_d = ST_GOT_H0;
          else                        state_d = ST_IDLE;
        end
        ST_GET_LEN: begin
          if ((rx_data_i == 8'd0) || (rx_data_i > MAX_LEN_B)) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            frame_len_d = rx_data_i;
            acc_d       = rx_data_i;
            cnt_d       = rx_data_i;
            state_d     = ST_DATA;
          end
        end
        ST_DATA: begin
          acc_d      = acc_q + rx_data_i;
          cnt_d      = cnt_q - 8'd1;
          pl_valid_d = 1'b1;
          pl_data_d  = rx_data_i;
          pl_first_d = (cnt_q == frame_len_q);
          pl_last_d  = (cnt_q == 8'd1);
          if (cnt_q == 8'd1) state_d = ST_GET_CHK;
        end
        ST_GET_CHK: begin
          if (rx_data_i == acc_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset drops any partial frame silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= 8'd0;
      cnt_q       <= 8'd0;
      frame_len_q <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_data_q   <= 8'd0;
      pl_first_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      frame_len_q <= frame_len_d;
      pl_valid_q  <= pl_valid_d;
      pl_data_q   <= pl_data_d;
      pl_first_q  <= pl_first_d;
      pl_last_q   <= pl_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign pl_valid_o   = pl_valid_q;
  assign pl_data_o    = pl_data_q;
  assign pl_first_o   = pl_first_q;
  assign pl_last_o    = pl_last_q;
  assign frame_len_o  = frame_len_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - directed self-checking bench for uart_rx_frame_parser
module tb_uart_rx_frame_parser;

  // 1 MHz / 100 kBd -> 10 cycles per bit, 4 byte times of 10 bits
  localparam int TMO = 400;

  logic       clk;
  logic       rst;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       pl_valid_o;
  logic [7:0] pl_data_o;
  logic       pl_first_o;
  logic       pl_last_o;
  logic [7:0] frame_len_o;
  logic       frame_done_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;

  int total;
  int bad;

  uart_rx_frame_parser #(
    .CLK_FREQ (32'd1_000_000),
    .BAUDRATE (32'd100_000),
    .MAX_LEN  (64),
    .HDR0     (8'h55),
    .HDR1     (8'hAA),
    .GAP_BYTES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .pl_valid_o  (pl_valid_o),
    .pl_data_o   (pl_data_o),
    .pl_first_o  (pl_first_o),
    .pl_last_o   (pl_last_o),
    .frame_len_o (frame_len_o),
    .frame_done_o(frame_done_o),
    .frame_err_o (frame_err_o),
    .err_code_o  (err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe one byte; outputs are sampled 1 cycle later. flags = {valid, first, last, done, err}
  task automatic send(input string tag, input logic [7:0] b, input logic [4:0] flags, input logic [7:0] exp_data);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    chk(tag, {27'd0, pl_valid_o, pl_first_o, pl_last_o, frame_done_o, frame_err_o}, {27'd0, flags});
    if (flags[4]) chk({tag, "_data"}, {24'd0, pl_data_o}, {24'd0, exp_data});
  endtask

  task automatic hdr(input string tag);
    send({tag, "_h0"}, 8'h55, 5'b00000, 8'h00);
    send({tag, "_h1"}, 8'hAA, 5'b00000, 8'h00);
  endtask

  task automatic good_frame(input string tag);
    hdr(tag);
    send({tag, "_len"}, 8'h03, 5'b00000, 8'h00);
    send({tag, "_p0"},  8'h11, 5'b11000, 8'h11);
    send({tag, "_p1"},  8'h22, 5'b10000, 8'h22);
    send({tag, "_p2"},  8'h33, 5'b10100, 8'h33);
    send({tag, "_chk"}, 8'h69, 5'b00010, 8'h00);
    chk({tag, "_len_o"}, {24'd0, frame_len_o}, 32'd3);
  endtask

  initial begin
    int quiet;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outs", {16'd0, pl_valid_o, pl_data_o, pl_first_o, pl_last_o, frame_len_o, frame_done_o, frame_err_o, err_code_o}, 32'd0);

    // Good frame
    good_frame("good");

    // Bad checksum, then good LEN=1 frame straight after
    hdr("badchk");
    send("badchk_len", 8'h02, 5'b00000, 8'h00);
    send("badchk_p0",  8'h01, 5'b11000, 8'h01);
    send("badchk_p1",  8'h02, 5'b10100, 8'h02);
    send("badchk_chk", 8'h00, 5'b00001, 8'h00);
    chk("badchk_code", {30'd0, err_code_o}, 32'd1);
    hdr("len1");
    send("len1_len", 8'h01, 5'b00000, 8'h00);
    send("len1_p0",  8'h7F, 5'b11100, 8'h7F);
    send("len1_chk", 8'h80, 5'b00010, 8'h00);

    // Bad lengths, frame_len_o holds the last accepted LEN
    hdr("len0");
    send("len0_len", 8'h00, 5'b00001, 8'h00);
    chk("len0_code", {30'd0, err_code_o}, 32'd0);
    hdr("len65");
    send("len65_len", 8'h41, 5'b00001, 8'h00);
    chk("len65_code", {30'd0, err_code_o}, 32'd0);
    send("len65_after", 8'h01, 5'b00000, 8'h00);
    chk("len_hold", {24'd0, frame_len_o}, 32'd1);

    // Header resync
    send("rs_junk", 8'h12, 5'b00000, 8'h00);
    send("rs_h0a",  8'h55, 5'b00000, 8'h00);
    send("rs_h0b",  8'h55, 5'b00000, 8'h00);
    send("rs_h1",   8'hAA, 5'b00000, 8'h00);
    send("rs_len",  8'h01, 5'b00000, 8'h00);
    send("rs_p0",   8'h05, 5'b11100, 8'h05);
    send("rs_chk",  8'h06, 5'b00010, 8'h00);

    // Maximum length 64: payload 0..63, checksum (0x40 + 2016) mod 256 = 0x20
    hdr("max");
    send("max_len", 8'h40, 5'b00000, 8'h00);
    for (int i = 0; i < 64; i++) begin
      send("max_p", 8'(i), (i == 0) ? 5'b11000 : (i == 63) ? 5'b10100 : 5'b10000, 8'(i));
    end
    send("max_chk", 8'h20, 5'b00010, 8'h00);
    chk("max_len_o", {24'd0, frame_len_o}, 32'd64);

    // Gap timeout mid-payload
    hdr("tmo");
    send("tmo_len", 8'h04, 5'b00000, 8'h00);
    send("tmo_p0",  8'h01, 5'b11000, 8'h01);
    quiet = 0;
    for (int i = 1; i < TMO; i++) begin
      @(posedge clk);
      #1;
      if (frame_err_o || frame_done_o || pl_valid_o) quiet++;
    end
    chk("tmo_early", quiet, 0);
    @(posedge clk);
    #1;
    chk("tmo_err", {31'd0, frame_err_o}, 32'd1);
    chk("tmo_code", {30'd0, err_code_o}, 32'd2);
    @(posedge clk);
    #1;
    chk("tmo_single", {31'd0, frame_err_o}, 32'd0);

    // Timeout from GOT_H0
    send("tmo_h0", 8'h55, 5'b00000, 8'h00);
    repeat (TMO) @(posedge clk);
    #1;
    chk("tmo_h0_err", {30'd0, frame_err_o, frame_done_o}, 32'd2);

    // Byte on the expiry cycle wins; checksum 04+01+02+03+04 = 0E
    hdr("race");
    send("race_len", 8'h04, 5'b00000, 8'h00);
    send("race_p0",  8'h01, 5'b11000, 8'h01);
    repeat (TMO - 1) @(posedge clk);
    #1;
    send("race_p1",  8'h02, 5'b10000, 8'h02);
    send("race_p2",  8'h03, 5'b10000, 8'h03);
    send("race_p3",  8'h04, 5'b10100, 8'h04);
    send("race_chk", 8'h0E, 5'b00010, 8'h00);

    // Reset mid-frame, then a clean frame
    hdr("rst");
    send("rst_len", 8'h03, 5'b00000, 8'h00);
    send("rst_p0",  8'h01, 5'b11000, 8'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_outs", {16'd0, pl_valid_o, pl_data_o, pl_first_o, pl_last_o, frame_len_o, frame_done_o, frame_err_o, err_code_o}, 32'd0);
    quiet = 0;
    for (int i = 0; i < TMO + 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_err_o || frame_done_o || pl_valid_o) quiet++;
    end
    chk("rst_silent", quiet, 0);
    good_frame("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of the UART receiver. It consumes that block's byte stream (rx_valid/rx_data) and delineates fixed-format command frames.
- Frame format: HDR0, HDR1, LEN, LEN payload bytes, CHK.
- Payload bytes are forwarded cut-through with first/last markers.
- Each frame ends with exactly one pulse: done (good) or err (bad), plus an error code.
- An inter-byte gap timer aborts stalled frames.

Parameters:
- CLK_FREQ, 32'd50_000_000, system clock frequency in Hz.
- BAUDRATE, 32'd115_200, UART baud rate; used only to size the gap timeout.
- MAX_LEN, 64, maximum legal LEN value (1..255).
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.
- GAP_BYTES, 4, timeout length in byte times. One byte time is 10 bits. TIMEOUT_CYC = (CLK_FREQ/BAUDRATE)*10*GAP_BYTES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid_i  in  1  one-cycle strobe from the UART receiver: a byte is available.
- rx_data_i  in  8  received byte; sampled only when rx_valid_i=1.
- pl_valid_o  out  1  payload byte strobe (single cycle).
- pl_data_o  out  8  payload byte; valid while pl_valid_o=1.
- pl_first_o  out  1  high with pl_valid_o on payload byte 0.
- pl_last_o  out  1  high with pl_valid_o on payload byte LEN-1.
- frame_len_o  out  8  LEN of the current/last frame; updated when LEN is accepted, held otherwise.
- frame_done_o  out  1  one-cycle pulse: frame completed with correct CHK.
- frame_err_o  out  1  one-cycle pulse: frame aborted.
- err_code_o  out  2  valid with frame_err_o, held until the next error:
  - 0 = bad LEN
  - 1 = checksum mismatch
  - 2 = gap timeout
  - 3 = reserved.

Behaviour:
- Reset: all outputs are 0, state=IDLE, timer=0, checksum accumulator=0. Reset mid-frame discards the frame silently (no err pulse).
- FSM states: IDLE, GOT_H0, GET_LEN, DATA, GET_CHK. Transitions happen only on rx_valid_i=1, except the timeout.
- IDLE:
  - byte==HDR0 -> GOT_H0.
  - Any other byte is ignored.
- GOT_H0:
  - byte==HDR1 -> GET_LEN.
  - byte==HDR0 -> stay in GOT_H0.
  - Otherwise -> IDLE. No error is reported.
- GET_LEN:
  - LEN==0 or LEN>MAX_LEN -> frame_err_o with code 0, then IDLE.
  - Otherwise: latch LEN into frame_len_o, acc=LEN, remaining count=LEN, go to DATA.
- DATA:
  - Each byte: acc=acc+byte (mod 256), output it on pl_*, decrement count.
  - At count==1 (the last byte): assert pl_last_o and go to GET_CHK.
  - LEN==1 gives pl_first_o and pl_last_o together.
- GET_CHK:
  - byte==acc -> frame_done_o.
  - Otherwise -> frame_err_o with code 1.
  - Either way -> IDLE.
- Output latency: all pl_* outputs and the done/err pulses are registered, appearing 1 cycle after the rx_valid_i strobe of the byte that caused them.
- Header bytes are never forwarded on pl_*.
- Gap timer:
  - Runs in every state except IDLE.
  - Clears to 0 on each accepted rx_valid_i and on entering IDLE.
  - When it reaches TIMEOUT_CYC-1 with rx_valid_i=0: frame_err_o with code 2, then IDLE.
  - Timeout is also reported from GOT_H0 and GET_LEN.
- Simultaneous events: a byte arriving on the expiry cycle wins. The byte is processed and the timer clears.
- At most one of frame_done_o/frame_err_o pulses per frame.
- Consumers must discard forwarded payload when frame_err_o follows.
- After done/err, the parser is in IDLE and hunts for a header with no dead cycle. A HDR0 byte on the cycle immediately after CHK is accepted.
- Width rules:
  - The timer is wide enough to hold TIMEOUT_CYC (32 bits).
  - The checksum wraps mod 256.
  - The remaining count is 8 bits.

Decomposition:
- Shared package uart_pkg holds:
  - parser state enum;
  - error code constants ERR_LEN=2'd0, ERR_CHK=2'd1, ERR_TMO=2'd2;
  - default header constants 8'h55/8'hAA.
- Natural sub-module: uart_gap_timer. It is a load/clear counter with a parameterised terminal count, producing an expire strobe, and is reusable by the receiver itself.

Test Plan:
- Good frame: send 55 AA 03 11 22 33 69 -> pl bytes 11 (first), 22, 33 (last), frame_len_o=3, then frame_done_o one cycle after 69; no err.
- Bad checksum: send 55 AA 02 01 02 00 -> 01, 02 forwarded; frame_err_o with err_code_o=1; next frame 55 AA 01 7F 80 -> frame_done_o.
- Bad length:
  - send 55 AA 00 -> err code 0;
  - send 55 AA 41 (MAX_LEN=64) -> err code 0;
  - in both cases no pl_valid_o.
- Header resync: send 12 55 55 AA 01 05 06 -> single payload byte 05 with first=last=1, then done; byte 12 and the extra 55 ignored.
- Timeout: send 55 AA 04 01 then idle for TIMEOUT_CYC cycles -> frame_err_o code 2 exactly at expiry. Also check a byte arriving on the expiry cycle is accepted with no err.
- Reset mid-frame: send 55 AA 03 01, assert rst for 1 cycle -> all outputs 0, no pulses; then a full good frame completes with done.
